// File: rtl/n101_qspi_rd_seq_pkg.sv
// Shared constants and state encoding for the QSPI read-command sequencer.
package n101_qspi_rd_seq_pkg;

    // Chip-select modes understood by the QSPI FIFO block.
    localparam logic [1:0] CS_MODE_AUTO = 2'h0;
    localparam logic [1:0] CS_MODE_HOLD = 2'h2;
    localparam logic [1:0] CS_MODE_OFF  = 2'h3;

    // Frame protocol widths understood by the QSPI FIFO block.
    localparam logic [1:0] PROTO_SINGLE = 2'h0;
    localparam logic [1:0] PROTO_DUAL   = 2'h1;
    localparam logic [1:0] PROTO_QUAD   = 2'h2;

    // Sequencer states; the encoding is visible on the dbg_state port.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_ADDR    = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DUMMY   = 3'd4,
        ST_COLLECT = 3'd5,
        ST_RSP     = 3'd6
    } state_e;

    // Address bytes go out most significant first: index 0 -> addr[23:16].
    function automatic logic [7:0] addr_byte(input logic [23:0] addr, input logic [1:0] idx);
        case (idx)
            2'd0:    return addr[23:16];
            2'd1:    return addr[15:8];
            default: return addr[7:0];
        endcase
    endfunction

endpackage

// File: rtl/n101_qspi_rd_seq.sv
// QSPI read-command sequencer: turns one 24-bit read request into the
// command/address/dummy byte stream for the QSPI FIFO block and assembles
// the returned rx bytes (little-endian) into a single response word.
//
// Handshakes (req, rsp, fifo_tx, fifo_rx): a transfer happens on a rising
// clock edge where valid and ready are both high; a source keeps valid high
// and its payload stable until that transfer, and valid never depends on
// ready combinationally.
module n101_qspi_rd_seq
    import n101_qspi_rd_seq_pkg::*;
#(
    parameter logic [7:0] CMD_BYTE   = 8'h03,
    parameter int         DATA_BYTES = 4      // 1..4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        busy,
    output logic [1:0]  ctrl_fmt_proto,
    output logic        ctrl_fmt_endian,
    output logic [3:0]  ctrl_fmt_len,
    output logic        ctrl_fmt_iodir,
    output logic [1:0]  ctrl_cs_mode,
    output logic [3:0]  ctrl_wm_tx,
    output logic [3:0]  ctrl_wm_rx,
    output logic        fifo_tx_valid,
    input  logic        fifo_tx_ready,
    output logic [7:0]  fifo_tx_bits,
    input  logic        fifo_rx_valid,
    output logic        fifo_rx_ready,
    input  logic [7:0]  fifo_rx_bits,
    input  logic        fifo_ip_txwm,
    output logic [2:0]  dbg_state
);

    localparam logic [2:0] NB = 3'(DATA_BYTES);

    state_e      state_q, state_d;
    logic [23:0] addr_q, addr_d;
    logic [1:0]  aidx_q, aidx_d;
    logic [2:0]  txcnt_q, txcnt_d;
    logic [2:0]  rxcnt_q, rxcnt_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [1:0]  cs_mode_q, cs_mode_d;
    logic        iodir_q, iodir_d;
    logic        rx_take;

    // An rx byte is kept only while receiving and only until the word is full.
    assign rx_take = fifo_rx_valid && (rxcnt_q < NB) &&
                     ((state_q == ST_DUMMY) || (state_q == ST_COLLECT));

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        aidx_d        = aidx_q;
        txcnt_d       = txcnt_q;
        rxcnt_d       = rxcnt_q;
        rsp_data_d    = rsp_data_q;
        cs_mode_d     = cs_mode_q;
        iodir_d       = iodir_q;
        req_ready     = 1'b0;
        rsp_valid     = 1'b0;
        fifo_tx_valid = 1'b0;
        fifo_tx_bits  = 8'h00;
        fifo_rx_ready = 1'b0;

        // Rx capture runs independently of the tx side so both counters can
        // advance in the same cycle.
        if (rx_take) begin
            rsp_data_d[{rxcnt_q[1:0], 3'b000} +: 8] = fifo_rx_bits;
            rxcnt_d = rxcnt_q + 3'd1;
        end

        case (state_q)
            ST_IDLE: begin
                req_ready     = 1'b1;
                fifo_rx_ready = 1'b1;   // stray rx bytes are dropped here
                if (req_valid) begin
                    addr_d     = req_addr;
                    rsp_data_d = 32'h0;
                    txcnt_d    = 3'd0;
                    rxcnt_d    = 3'd0;
                    aidx_d     = 2'd0;
                    cs_mode_d  = CS_MODE_HOLD;
                    iodir_d    = 1'b1;
                    state_d    = ST_CMD;
                end
            end
            ST_CMD: begin
                fifo_tx_valid = 1'b1;
                fifo_tx_bits  = CMD_BYTE;
                if (fifo_tx_ready) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                fifo_tx_valid = 1'b1;
                fifo_tx_bits  = addr_byte(addr_q, aidx_q);
                if (fifo_tx_ready) begin
                    aidx_d = aidx_q + 2'd1;
                    if (aidx_q == 2'd2) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Direction may only flip once the tx queue is empty.
                if (fifo_ip_txwm) begin
                    iodir_d = 1'b0;
                    state_d = ST_DUMMY;
                end
            end
            ST_DUMMY: begin
                fifo_tx_valid = 1'b1;
                fifo_rx_ready = 1'b1;
                if (fifo_tx_ready) begin
                    txcnt_d = txcnt_q + 3'd1;
                    if (txcnt_d == NB) begin
                        if (rxcnt_d == NB) begin
                            cs_mode_d = CS_MODE_AUTO;
                            iodir_d   = 1'b1;
                            state_d   = ST_RSP;
                        end else begin
                            state_d = ST_COLLECT;
                        end
                    end
                end
            end
            ST_COLLECT: begin
                fifo_rx_ready = 1'b1;
                if (rxcnt_d == NB) begin
                    cs_mode_d = CS_MODE_AUTO;
                    iodir_d   = 1'b1;
                    state_d   = ST_RSP;
                end
            end
            ST_RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= 24'h0;
            aidx_q     <= 2'd0;
            txcnt_q    <= 3'd0;
            rxcnt_q    <= 3'd0;
            rsp_data_q <= 32'h0;
            cs_mode_q  <= CS_MODE_AUTO;
            iodir_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            aidx_q     <= aidx_d;
            txcnt_q    <= txcnt_d;
            rxcnt_q    <= rxcnt_d;
            rsp_data_q <= rsp_data_d;
            cs_mode_q  <= cs_mode_d;
            iodir_q    <= iodir_d;
        end
    end

    assign busy            = (state_q != ST_IDLE);
    assign rsp_data        = rsp_data_q;
    assign ctrl_fmt_proto  = PROTO_SINGLE;
    assign ctrl_fmt_endian = 1'b0;
    assign ctrl_fmt_len    = 4'h8;
    assign ctrl_fmt_iodir  = iodir_q;
    assign ctrl_cs_mode    = cs_mode_q;
    assign ctrl_wm_tx      = 4'h1;
    assign ctrl_wm_rx      = 4'h0;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_n101_qspi_rd_seq.sv
// Directed self-checking bench for n101_qspi_rd_seq: a 4-byte instance driven
// by a small FIFO responder, and a 1-byte instance driven by hand.
module tb_n101_qspi_rd_seq;
    import n101_qspi_rd_seq_pkg::*;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    // ---------------- DUT (DATA_BYTES = 4) ----------------
    logic        req_valid = 1'b0, req_ready;
    logic [23:0] req_addr = 24'h0;
    logic        rsp_valid, rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        busy, fmt_endian, iodir;
    logic [1:0]  fmt_proto, cs_mode;
    logic [3:0]  fmt_len, wm_tx, wm_rx;
    logic        tx_valid, tx_ready = 1'b1;
    logic [7:0]  tx_bits;
    logic        rx_valid = 1'b0, rx_ready;
    logic [7:0]  rx_bits = 8'h00;
    logic        txwm = 1'b1;
    logic [2:0]  dbg_state;

    n101_qspi_rd_seq dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy), .ctrl_fmt_proto(fmt_proto), .ctrl_fmt_endian(fmt_endian),
        .ctrl_fmt_len(fmt_len), .ctrl_fmt_iodir(iodir), .ctrl_cs_mode(cs_mode),
        .ctrl_wm_tx(wm_tx), .ctrl_wm_rx(wm_rx),
        .fifo_tx_valid(tx_valid), .fifo_tx_ready(tx_ready), .fifo_tx_bits(tx_bits),
        .fifo_rx_valid(rx_valid), .fifo_rx_ready(rx_ready), .fifo_rx_bits(rx_bits),
        .fifo_ip_txwm(txwm), .dbg_state(dbg_state)
    );

    // ---------------- DUT (DATA_BYTES = 1) ----------------
    logic        req_valid1 = 1'b0, req_ready1;
    logic [23:0] req_addr1 = 24'h0;
    logic        rsp_valid1, rsp_ready1 = 1'b1;
    logic [31:0] rsp_data1;
    logic        busy1, fmt_endian1, iodir1;
    logic [1:0]  fmt_proto1, cs_mode1;
    logic [3:0]  fmt_len1, wm_tx1, wm_rx1;
    logic        tx_valid1, tx_ready1 = 1'b1;
    logic [7:0]  tx_bits1;
    logic        rx_valid1 = 1'b0, rx_ready1;
    logic [7:0]  rx_bits1 = 8'h00;
    logic        txwm1 = 1'b1;
    logic [2:0]  dbg_state1;

    n101_qspi_rd_seq #(.CMD_BYTE(8'h03), .DATA_BYTES(1)) dut1 (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_addr(req_addr1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_data(rsp_data1),
        .busy(busy1), .ctrl_fmt_proto(fmt_proto1), .ctrl_fmt_endian(fmt_endian1),
        .ctrl_fmt_len(fmt_len1), .ctrl_fmt_iodir(iodir1), .ctrl_cs_mode(cs_mode1),
        .ctrl_wm_tx(wm_tx1), .ctrl_wm_rx(wm_rx1),
        .fifo_tx_valid(tx_valid1), .fifo_tx_ready(tx_ready1), .fifo_tx_bits(tx_bits1),
        .fifo_rx_valid(rx_valid1), .fifo_rx_ready(rx_ready1), .fifo_rx_bits(rx_bits1),
        .fifo_ip_txwm(txwm1), .dbg_state(dbg_state1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- FIFO responder for dut ----------------
    // Every dummy tx byte produces one rx byte one cycle later; the n-th rx
    // byte of a request is rx_base + 8'h11*n.
    logic       bp_en = 1'b0;       // toggle tx_ready every cycle
    logic       txwm_block = 1'b0;  // hold fifo_ip_txwm low
    logic [7:0] rx_base = 8'h00;
    logic [7:0] rx_k = 8'h00;
    logic [7:0] act_q[$];           // every tx byte the DUT handed over
    logic [7:0] pend[$];            // rx bytes waiting to be presented

    always @(negedge clock) begin
        if (rx_valid && rx_ready && pend.size() != 0) void'(pend.pop_front());
        if (req_valid && req_ready) begin
            pend.delete();
            rx_k <= 8'h00;
        end
        if (tx_valid && tx_ready) begin
            act_q.push_back(tx_bits);
            if (!iodir) begin
                pend.push_back(rx_base + 8'h11 * rx_k);
                rx_k <= rx_k + 8'h01;
            end
        end
    end

    always @(posedge clock) begin
        #1;
        tx_ready <= bp_en ? ~tx_ready : 1'b1;
        txwm     <= ~txwm_block;
        rx_valid <= (pend.size() != 0);
        rx_bits  <= (pend.size() != 0) ? pend[0] : 8'h00;
    end

    // Safety net against a hung run.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clock);
        n_checks++; if ({busy, req_ready, rsp_valid} !== 3'b010) begin n_fail++;
            $display("FAIL reset_hs: got busy/req_ready/rsp_valid=%b expected 010", {busy, req_ready, rsp_valid}); end
        n_checks++; if (rsp_data !== 32'h0) begin n_fail++;
            $display("FAIL reset_rsp_data: got %h expected 00000000", rsp_data); end
        n_checks++; if ({tx_valid, tx_bits, rx_ready} !== {1'b0, 8'h00, 1'b1}) begin n_fail++;
            $display("FAIL reset_fifo: got tx_valid=%b tx_bits=%h rx_ready=%b expected 0 00 1", tx_valid, tx_bits, rx_ready); end
        n_checks++; if ({cs_mode, iodir} !== {CS_MODE_AUTO, 1'b1}) begin n_fail++;
            $display("FAIL reset_ctrl: got cs=%0d iodir=%b expected 0 1", cs_mode, iodir); end
        n_checks++; if ({fmt_proto, fmt_endian, fmt_len, wm_tx, wm_rx} !== {2'h0, 1'b0, 4'h8, 4'h1, 4'h0}) begin n_fail++;
            $display("FAIL reset_const: got proto=%h endian=%b len=%h wm_tx=%h wm_rx=%h expected 0 0 8 1 0",
                     fmt_proto, fmt_endian, fmt_len, wm_tx, wm_rx); end
        n_checks++; if ({busy1, req_ready1, rsp_valid1, cs_mode1, iodir1} !== {3'b010, 2'h0, 1'b1}) begin n_fail++;
            $display("FAIL reset_dut1: got busy/req_ready/rsp_valid/cs/iodir=%b expected 010001", {busy1, req_ready1, rsp_valid1, cs_mode1, iodir1}); end
        reset_n = 1'b1;
    endtask

    task automatic test_basic_read();
        logic [7:0] exp_q[$];
        int start, lat;
        exp_q = '{8'h03, 8'h12, 8'h34, 8'h56, 8'h00, 8'h00, 8'h00, 8'h00};
        @(negedge clock);
        rx_base = 8'h11; rsp_ready = 1'b1; start = act_q.size();
        n_checks++; if (req_ready !== 1'b1) begin n_fail++;
            $display("FAIL basic_req_ready: got %b expected 1", req_ready); end
        req_valid = 1'b1; req_addr = 24'h123456;
        @(negedge clock);           // cycle 1
        req_valid = 1'b0;
        n_checks++; if ({dbg_state, cs_mode, tx_valid, tx_bits, rx_ready, busy} !== {ST_CMD, CS_MODE_HOLD, 1'b1, 8'h03, 1'b0, 1'b1}) begin n_fail++;
            $display("FAIL basic_cycle1: got state=%0d cs=%0d tx_valid=%b tx_bits=%h rx_ready=%b busy=%b expected 1 2 1 03 0 1",
                     dbg_state, cs_mode, tx_valid, tx_bits, rx_ready, busy); end
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 40) begin @(negedge clock); lat++; end
        n_checks++; if (lat != 11) begin n_fail++;
            $display("FAIL basic_latency: got %0d expected 11", lat); end
        n_checks++; if (rsp_data !== 32'h44332211) begin n_fail++;
            $display("FAIL basic_rsp_data: got %h expected 44332211", rsp_data); end
        n_checks++; if ({cs_mode, iodir} !== {CS_MODE_AUTO, 1'b1}) begin n_fail++;
            $display("FAIL basic_cs_release: got cs=%0d iodir=%b expected 0 1", cs_mode, iodir); end
        @(negedge clock);
        n_checks++; if ({req_ready, busy, rsp_valid} !== 3'b100) begin n_fail++;
            $display("FAIL basic_back_idle: got req_ready/busy/rsp_valid=%b expected 100", {req_ready, busy, rsp_valid}); end
        n_checks++; if (act_q.size() - start != 8) begin n_fail++;
            $display("FAIL basic_tx_count: got %0d expected 8", act_q.size() - start); end
        for (int i = 0; i < 8 && start + i < act_q.size(); i++) begin
            n_checks++; if (act_q[start + i] !== exp_q[i]) begin n_fail++;
                $display("FAIL basic_tx_byte%0d: got %h expected %h", i, act_q[start + i], exp_q[i]); end
        end
    endtask

    task automatic test_tx_backpressure();
        logic [7:0] exp_q[$];
        logic [7:0] prev_bits;
        logic       prev_stall;
        int start, cyc, stalls;
        exp_q = '{8'h03, 8'hAB, 8'hCD, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h00};
        @(negedge clock);
        bp_en = 1'b1; rx_base = 8'h20; rsp_ready = 1'b1; start = act_q.size();
        req_valid = 1'b1; req_addr = 24'hABCDEF;
        @(negedge clock);
        req_valid = 1'b0;
        prev_stall = 1'b0; prev_bits = 8'h00; cyc = 0; stalls = 0;
        while (rsp_valid !== 1'b1 && cyc < 80) begin
            if (prev_stall) begin
                stalls++;
                n_checks++; if (tx_valid !== 1'b1 || tx_bits !== prev_bits) begin n_fail++;
                    $display("FAIL bp_stall_hold: got tx_valid=%b tx_bits=%h expected 1 %h", tx_valid, tx_bits, prev_bits); end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_bits  = tx_bits;
            @(negedge clock); cyc++;
        end
        n_checks++; if (rsp_valid !== 1'b1 || stalls == 0) begin n_fail++;
            $display("FAIL bp_progress: got rsp_valid=%b stalls=%0d expected 1 and >0", rsp_valid, stalls); end
        n_checks++; if (rsp_data !== 32'h53423120) begin n_fail++;
            $display("FAIL bp_rsp_data: got %h expected 53423120", rsp_data); end
        @(negedge clock);
        bp_en = 1'b0;
        n_checks++; if (act_q.size() - start != 8) begin n_fail++;
            $display("FAIL bp_tx_count: got %0d expected 8", act_q.size() - start); end
        for (int i = 0; i < 8 && start + i < act_q.size(); i++) begin
            n_checks++; if (act_q[start + i] !== exp_q[i]) begin n_fail++;
                $display("FAIL bp_tx_byte%0d: got %h expected %h", i, act_q[start + i], exp_q[i]); end
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic test_drain_gate();
        logic [7:0] exp_q[$];
        int start, cyc;
        exp_q = '{8'h03, 8'h0F, 8'h1E, 8'h2D, 8'h00, 8'h00, 8'h00, 8'h00};
        @(negedge clock);
        txwm_block = 1'b1; rx_base = 8'h01; rsp_ready = 1'b1; start = act_q.size();
        req_valid = 1'b1; req_addr = 24'h0F1E2D;
        @(negedge clock);
        req_valid = 1'b0;
        cyc = 0;
        while (dbg_state !== ST_DRAIN && cyc < 20) begin @(negedge clock); cyc++; end
        n_checks++; if (dbg_state !== ST_DRAIN) begin n_fail++;
            $display("FAIL drain_reach: got state=%0d expected 3", dbg_state); end
        for (int i = 0; i < 10; i++) begin
            n_checks++; if ({dbg_state, tx_valid, iodir, rx_ready} !== {ST_DRAIN, 1'b0, 1'b1, 1'b0}) begin n_fail++;
                $display("FAIL drain_hold%0d: got state=%0d tx_valid=%b iodir=%b rx_ready=%b expected 3 0 1 0",
                         i, dbg_state, tx_valid, iodir, rx_ready); end
            @(negedge clock);
        end
        txwm_block = 1'b0;
        @(negedge clock);           // txwm now high, not yet sampled
        n_checks++; if ({dbg_state, iodir} !== {ST_DRAIN, 1'b1}) begin n_fail++;
            $display("FAIL drain_edge: got state=%0d iodir=%b expected 3 1", dbg_state, iodir); end
        @(negedge clock);
        n_checks++; if ({dbg_state, iodir, tx_valid, tx_bits} !== {ST_DUMMY, 1'b0, 1'b1, 8'h00}) begin n_fail++;
            $display("FAIL drain_exit: got state=%0d iodir=%b tx_valid=%b tx_bits=%h expected 4 0 1 00",
                     dbg_state, iodir, tx_valid, tx_bits); end
        cyc = 0;
        while (rsp_valid !== 1'b1 && cyc < 40) begin @(negedge clock); cyc++; end
        n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h34231201) begin n_fail++;
            $display("FAIL drain_rsp: got valid=%b data=%h expected 1 34231201", rsp_valid, rsp_data); end
        @(negedge clock);
        n_checks++; if (act_q.size() - start != 8) begin n_fail++;
            $display("FAIL drain_tx_count: got %0d expected 8", act_q.size() - start); end
        for (int i = 0; i < 8 && start + i < act_q.size(); i++) begin
            n_checks++; if (act_q[start + i] !== exp_q[i]) begin n_fail++;
                $display("FAIL drain_tx_byte%0d: got %h expected %h", i, act_q[start + i], exp_q[i]); end
        end
    endtask

    task automatic test_rsp_stall_back_to_back();
        logic [7:0] exp_q[$];
        int start, cyc;
        exp_q = '{8'h03, 8'hC0, 8'hFF, 8'hEE, 8'h00, 8'h00, 8'h00, 8'h00};
        @(negedge clock);
        rx_base = 8'h05; rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 24'h00A0B0;
        @(negedge clock);
        req_valid = 1'b0;
        cyc = 0;
        while (rsp_valid !== 1'b1 && cyc < 40) begin @(negedge clock); cyc++; end
        for (int i = 0; i < 5; i++) begin
            n_checks++; if ({rsp_valid, req_ready, busy} !== 3'b101 || rsp_data !== 32'h38271605) begin n_fail++;
                $display("FAIL stall_hold%0d: got valid=%b req_ready=%b busy=%b data=%h expected 1 0 1 38271605",
                         i, rsp_valid, req_ready, busy, rsp_data); end
            if (i == 0) begin req_valid = 1'b1; req_addr = 24'hC0FFEE; end
            @(negedge clock);
        end
        rsp_ready = 1'b1;
        @(negedge clock);           // response fired; back in IDLE, request pending
        n_checks++; if ({req_ready, rsp_valid, busy} !== 3'b100) begin n_fail++;
            $display("FAIL stall_release: got req_ready=%b rsp_valid=%b busy=%b expected 1 0 0", req_ready, rsp_valid, busy); end
        rx_base = 8'h40; start = act_q.size();
        @(negedge clock);
        req_valid = 1'b0;
        n_checks++; if ({dbg_state, tx_bits} !== {ST_CMD, 8'h03}) begin n_fail++;
            $display("FAIL b2b_accept: got state=%0d tx_bits=%h expected 1 03", dbg_state, tx_bits); end
        cyc = 0;
        while (rsp_valid !== 1'b1 && cyc < 40) begin @(negedge clock); cyc++; end
        n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h73625140) begin n_fail++;
            $display("FAIL b2b_rsp: got valid=%b data=%h expected 1 73625140", rsp_valid, rsp_data); end
        @(negedge clock);
        n_checks++; if (act_q.size() - start != 8) begin n_fail++;
            $display("FAIL b2b_tx_count: got %0d expected 8", act_q.size() - start); end
        for (int i = 0; i < 8 && start + i < act_q.size(); i++) begin
            n_checks++; if (act_q[start + i] !== exp_q[i]) begin n_fail++;
                $display("FAIL b2b_tx_byte%0d: got %h expected %h", i, act_q[start + i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_dummy();
        logic [7:0] exp_q[$];
        int start, cyc;
        exp_q = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        @(negedge clock);
        rx_base = 8'h77; rsp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 24'h654321;
        @(negedge clock);
        req_valid = 1'b0;
        cyc = 0;
        while (dbg_state !== ST_DUMMY && cyc < 20) begin @(negedge clock); cyc++; end
        @(negedge clock);
        n_checks++; if ({dbg_state, cs_mode, iodir} !== {ST_DUMMY, CS_MODE_HOLD, 1'b0}) begin n_fail++;
            $display("FAIL rst_pre: got state=%0d cs=%0d iodir=%b expected 4 2 0", dbg_state, cs_mode, iodir); end
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        n_checks++; if ({busy, req_ready, rsp_valid, tx_valid, tx_bits, rx_ready} !== {3'b010, 1'b0, 8'h00, 1'b1}) begin n_fail++;
            $display("FAIL rst_hs: got busy=%b req_ready=%b rsp_valid=%b tx_valid=%b tx_bits=%h rx_ready=%b expected 0 1 0 0 00 1",
                     busy, req_ready, rsp_valid, tx_valid, tx_bits, rx_ready); end
        n_checks++; if ({cs_mode, iodir} !== {CS_MODE_AUTO, 1'b1} || rsp_data !== 32'h0) begin n_fail++;
            $display("FAIL rst_ctrl: got cs=%0d iodir=%b data=%h expected 0 1 00000000", cs_mode, iodir, rsp_data); end
        rx_base = 8'h5A; start = act_q.size();
        req_valid = 1'b1; req_addr = 24'h000000;
        @(negedge clock);
        req_valid = 1'b0;
        cyc = 0;
        while (rsp_valid !== 1'b1 && cyc < 40) begin @(negedge clock); cyc++; end
        n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h8D7C6B5A) begin n_fail++;
            $display("FAIL rst_reread: got valid=%b data=%h expected 1 8D7C6B5A", rsp_valid, rsp_data); end
        @(negedge clock);
        n_checks++; if (act_q.size() - start != 8) begin n_fail++;
            $display("FAIL rst_tx_count: got %0d expected 8", act_q.size() - start); end
        for (int i = 0; i < 8 && start + i < act_q.size(); i++) begin
            n_checks++; if (act_q[start + i] !== exp_q[i]) begin n_fail++;
                $display("FAIL rst_tx_byte%0d: got %h expected %h", i, act_q[start + i], exp_q[i]); end
        end
    endtask

    task automatic test_single_byte();
        @(negedge clock);
        rsp_ready1 = 1'b1; tx_ready1 = 1'b1; txwm1 = 1'b1;
        rx_valid1 = 1'b1; rx_bits1 = 8'hA5;     // held valid throughout
        req_valid1 = 1'b1; req_addr1 = 24'h00C3D2;
        n_checks++; if (rx_ready1 !== 1'b1) begin n_fail++;
            $display("FAIL one_idle_rx_ready: got %b expected 1", rx_ready1); end
        @(negedge clock);           // cycle 1
        req_valid1 = 1'b0;
        n_checks++; if ({dbg_state1, rx_ready1, tx_bits1} !== {ST_CMD, 1'b0, 8'h03}) begin n_fail++;
            $display("FAIL one_cmd: got state=%0d rx_ready=%b tx_bits=%h expected 1 0 03", dbg_state1, rx_ready1, tx_bits1); end
        repeat (4) @(negedge clock);    // cycle 5
        n_checks++; if ({dbg_state1, rx_ready1, tx_valid1} !== {ST_DRAIN, 1'b0, 1'b0}) begin n_fail++;
            $display("FAIL one_drain: got state=%0d rx_ready=%b tx_valid=%b expected 3 0 0", dbg_state1, rx_ready1, tx_valid1); end
        @(negedge clock);           // cycle 6
        n_checks++; if ({dbg_state1, tx_valid1, tx_bits1, rx_ready1, iodir1} !== {ST_DUMMY, 1'b1, 8'h00, 1'b1, 1'b0}) begin n_fail++;
            $display("FAIL one_dummy: got state=%0d tx_valid=%b tx_bits=%h rx_ready=%b iodir=%b expected 4 1 00 1 0",
                     dbg_state1, tx_valid1, tx_bits1, rx_ready1, iodir1); end
        @(negedge clock);           // cycle 7
        rx_valid1 = 1'b0;
        n_checks++; if ({dbg_state1, rsp_valid1, cs_mode1, iodir1} !== {ST_RSP, 1'b1, CS_MODE_AUTO, 1'b1}) begin n_fail++;
            $display("FAIL one_direct_rsp: got state=%0d rsp_valid=%b cs=%0d iodir=%b expected 6 1 0 1",
                     dbg_state1, rsp_valid1, cs_mode1, iodir1); end
        n_checks++; if (rsp_data1 !== 32'h000000A5) begin n_fail++;
            $display("FAIL one_rsp_data: got %h expected 000000A5", rsp_data1); end
        @(negedge clock);
        n_checks++; if ({req_ready1, busy1} !== 2'b10) begin n_fail++;
            $display("FAIL one_back_idle: got req_ready=%b busy=%b expected 1 0", req_ready1, busy1); end
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_tx_backpressure();
        test_drain_gate();
        test_rsp_stall_back_to_back();
        test_reset_mid_dummy();
        test_single_byte();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
